bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter, the inverse of the binary-to-BCD block that drives the seven-segment display path. It accepts a 4-digit packed BCD value, typically from keypad or switch digit entry, and produces the equivalent 14-bit unsigned binary value. Conversion uses the reverse double-dabble algorithm: one shift-and-correct iteration per clock and a `rdy`/`en` handshake. It sits between the digit-entry front end and the binary datapath.

## Interface
- `DIGITS`, default 4: number of BCD digits. The input is 4·`DIGITS` bits wide.
- `BIN_W`, default 14: binary output width. It must satisfy 2^`BIN_W` > 10^`DIGITS` − 1. It also sets the iteration count.
- `clk`, input, 1: system clock. All state changes occur on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `en`, input, 1: start request. Sampled only in IDLE.
- `bcd_d_in`, input, 16: packed BCD input. Digit 3 occupies [15:12] and digit 0 occupies [3:0].
- `bin_d_out`, output, 14: binary result. Registered, and held until the next successful conversion.
- `rdy`, output, 1: high when idle and `bin_d_out` is valid or stable.
- `err`, output, 1: set when the last start request contained a digit greater than 9.

## Operation
- **Reset values:**
  - state = IDLE
  - `bin_d_out` = 0
  - `rdy` = 1
  - `err` = 0
  - iteration counter = 0
- **States:** IDLE and SHIFT.
- **IDLE, `en`=1, all nibbles of `bcd_d_in` ≤ 9:**
  - Load the BCD working register from `bcd_d_in` and clear the binary working register.
  - Clear the counter and clear `err`.
  - Drive `rdy` low and go to SHIFT.
- **IDLE, `en`=1, any nibble > 9:**
  - Set `err`=1 and stay in IDLE.
  - `rdy` stays 1 and `bin_d_out` is unchanged.
- **IDLE, `en`=0:** hold all state.
- **SHIFT, each cycle, one iteration:**
  - Shift the concatenation {BCD working reg, binary working reg} right by 1. The BCD LSB enters the binary MSB.
  - Then, in every 4-bit BCD nibble, replace any value ≥ 8 with value − 3.
  - Shift and correction happen in the same cycle, combinationally chained before the register.
  - Increment the counter.
- **SHIFT, iteration `BIN_W` (counter = `BIN_W`−1):**
  - Write the post-shift binary working register to `bin_d_out`.
  - Set `rdy`=1 and return to IDLE.
  - The BCD working register is zero at this point for any legal input.
- **`en` in SHIFT:** ignored. Requests are neither queued nor aborting.
- **Arithmetic:** all unsigned. Nibble correction applies only to values 8–15. Results never exceed 9999 (0x270F).
- **Reset mid-conversion:** immediate abort to the reset values. The partial result is discarded.

## Timing
- **Latency:** `en` sampled high at edge E (in IDLE, valid input). `rdy` falls after E. `bin_d_out` updates and `rdy` rises after edge E+`BIN_W`, which is E+14.
- **Throughput:** with `en` held high, a new capture occurs at edge E+15. `rdy` is high for exactly one cycle between conversions, with period 15 cycles.
- **Invalid input:** `err` rises after edge E. No `rdy` drop.
- **Output stability:** `bin_d_out` changes only on the completion edge and is never glitched by in-progress iterations.
- **Reset:** outputs take their reset values asynchronously on `rst_n` falling. The first capture is possible on the first rising edge with `rst_n`=1.

## Structure
- **Shared package `bcd_pkg`:**
  - `DIGITS_DEF`=4
  - `BIN_W_DEF`=14
  - `BCD_MAX_DIGIT`=9
  - `ADJ_THRESH`=8
  - `ADJ_SUB`=3
  - state enum {IDLE, SHIFT}
  - The package is shared with the binary-to-BCD block, whose add-3 threshold is 5.
- **Sub-module `bcd_digit_adj`:** combinational, one per digit. Input is a 4-bit nibble; output is nibble − 3 if nibble ≥ 8, else the nibble. It is instantiated `DIGITS` times by generate.
- **Top-level contents:**
  - FSM
  - ⌈log2(`BIN_W`)⌉-bit counter
  - input digit-validity check
  - working registers

## Test plan
- **Reset:** assert `rst_n`=0 mid-simulation → `rdy`=1, `bin_d_out`=0, `err`=0 immediately. De-assert, then apply `en`=1 with 0x1024 → `bin_d_out`=0x400 (1024). `rdy` rises exactly 14 cycles after the capture edge.
- **Extremes:** 0x0000 → 0x0000. 0x9999 → 0x270F. 0x0001 → 0x0001. 0x8000 → 0x1F40.
- **Invalid digit:** previous result 0x0400, apply 0x12A4 with `en`=1 → `err`=1, `rdy` stays 1, `bin_d_out` stays 0x0400. Next apply 0x0042 → `err` clears at capture and the result is 0x002A.
- **Back-to-back:** `en` held high; 0x0512, then 0x0256 presented while `rdy` is high → results 0x0200, then 0x0100. `rdy` is high for one cycle between the conversions, with period 15.
- **Mid-conversion `en` and input changes:** toggle `en` and change `bcd_d_in` during SHIFT → the result matches the originally captured value.
- **Reset mid-conversion:** pulse `rst_n` low at iteration 7 → `bin_d_out`=0 and `rdy`=1. The next conversion of 0x0999 gives 0x03E7.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD <-> binary conversion blocks.
package bcd_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  // Reverse double-dabble corrects digits >= 8 by subtracting 3; the forward
  // binary-to-BCD block uses the mirror rule (>= 5, add 3).
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_SUB       = 4'd3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bcd2bin_if.sv
// Start/result handshake between the digit-entry front end and bcd2bin.
interface bcd2bin_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) ();

  logic                  en;
  logic [4*DIGITS-1:0]   bcd_d_in;
  logic [BIN_W-1:0]      bin_d_out;
  logic                  rdy;
  logic                  err;

  modport master (
    output en,
    output bcd_d_in,
    input  bin_d_out,
    input  rdy,
    input  err
  );

  modport slave (
    input  en,
    input  bcd_d_in,
    output bin_d_out,
    output rdy,
    output err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: nibbles of 8..15 lose 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] nibble_adj
);

  assign nibble_adj = (nibble >= ADJ_THRESH) ? (nibble - ADJ_SUB) : nibble;

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to unsigned binary converter, one reverse
// double-dabble iteration per clock with an en/rdy handshake.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input logic      clk,
  input logic      rst_n,
  bcd2bin_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t            state_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BCD_W-1:0]  bcd_shift;
  logic [BCD_W-1:0]  bcd_next;
  logic [BIN_W-1:0]  bin_reg;
  logic [BIN_W-1:0]  bin_next;
  logic [BIN_W-1:0]  bin_out_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              rdy_reg;
  logic              err_reg;
  logic [DIGITS-1:0] digit_ok;
  logic              in_valid;

  // Shift and per-digit correction are chained in one cycle.
  assign {bcd_shift, bin_next} = {bcd_reg, bin_reg} >> 1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_adj u_adj (
      .nibble     (bcd_shift[gi*4 +: 4]),
      .nibble_adj (bcd_next[gi*4 +: 4])
    );
    assign digit_ok[gi] = (bus.bcd_d_in[gi*4 +: 4] <= BCD_MAX_DIGIT);
  end

  assign in_valid = &digit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      bin_out_reg <= '0;
      cnt_reg     <= '0;
      rdy_reg     <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.en) begin
            if (in_valid) begin
              bcd_reg   <= bus.bcd_d_in;
              bin_reg   <= '0;
              cnt_reg   <= '0;
              err_reg   <= 1'b0;
              rdy_reg   <= 1'b0;
              state_reg <= SHIFT;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          cnt_reg <= cnt_reg + 1'b1;
          // The published result only moves on the final iteration.
          if (cnt_reg == LAST_ITER) begin
            bin_out_reg <= bin_next;
            rdy_reg     <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.bin_d_out = bin_out_reg;
  assign bus.rdy       = rdy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: directed vectors push expected results,
// a negedge monitor pops and compares on every rdy rise.
module tb_bcd2bin;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [13:0] sb_q[$];

  bcd2bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd2bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: result and latency checked on each rdy rise outside reset.
  logic prev_rdy = 1'b1;
  int   fall_cyc = 0;
  always @(negedge clk) begin
    logic [13:0] exp_v;
    if (!rst_n) begin
      prev_rdy = 1'b1;
    end else begin
      if (prev_rdy && !bus.rdy) fall_cyc = cyc;
      if (!prev_rdy && bus.rdy) begin
        check("latency", 32'(cyc - fall_cyc), 32'd14);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, expected none", bus.bin_d_out);
        end else begin
          exp_v = sb_q.pop_front();
          check("result", 32'(bus.bin_d_out), 32'(exp_v));
          $display("[TB] result 0x%04h expected 0x%04h at cycle %0d", bus.bin_d_out, exp_v, cyc);
        end
      end
      prev_rdy = bus.rdy;
    end
  end

  task automatic wait_rdy(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.rdy === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("[TB] FAIL rdy_timeout: got rdy=%b, expected 1 within %0d cycles", bus.rdy, max_cyc);
  endtask

  task automatic convert(input logic [15:0] bcd, input logic [13:0] exp);
    bit ok;
    wait_rdy(40, ok);
    bus.bcd_d_in = bcd;
    bus.en = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.en = 1'b0;
    check("capture_rdy", 32'(bus.rdy), 32'd0);
    check("capture_err", 32'(bus.err), 32'd0);
    wait_rdy(40, ok);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.en = 1'b0;
    bus.bcd_d_in = 16'h0000;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(bus.rdy), 32'd1);
    check("reset_bin", 32'(bus.bin_d_out), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Extremes.
    convert(16'h0000, 14'h0000);
    convert(16'h9999, 14'h270F);
    convert(16'h0001, 14'h0001);
    convert(16'h8000, 14'h1F40);

    // Asynchronous reset while idle with a non-zero result.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rdy", 32'(bus.rdy), 32'd1);
    check("async_reset_bin", 32'(bus.bin_d_out), 32'd0);
    check("async_reset_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    convert(16'h1024, 14'h0400);

    // Invalid digit: err only, result held, no rdy drop.
    bus.bcd_d_in = 16'h12A4;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    check("invalid_err", 32'(bus.err), 32'd1);
    check("invalid_rdy", 32'(bus.rdy), 32'd1);
    check("invalid_bin", 32'(bus.bin_d_out), 32'h0400);
    @(negedge clk);
    check("invalid_rdy_hold", 32'(bus.rdy), 32'd1);
    convert(16'h0042, 14'h002A);

    // Back-to-back with en held high.
    wait_rdy(40, ok);
    bus.bcd_d_in = 16'h0512;
    bus.en = 1'b1;
    sb_q.push_back(14'h0200);
    @(negedge clk);
    check("b2b_first_capture", 32'(bus.rdy), 32'd0);
    wait_rdy(40, ok);
    bus.bcd_d_in = 16'h0256;
    sb_q.push_back(14'h0100);
    @(negedge clk);
    check("b2b_rdy_one_cycle", 32'(bus.rdy), 32'd0);
    wait_rdy(40, ok);
    bus.en = 1'b0;
    @(negedge clk);
    check("b2b_idle_after_drop", 32'(bus.rdy), 32'd1);

    // en and input changes during SHIFT must not disturb the conversion.
    bus.bcd_d_in = 16'h0777;
    bus.en = 1'b1;
    sb_q.push_back(14'h0309);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.en = (i % 2 == 0);
      bus.bcd_d_in = (i % 2 == 0) ? 16'h9999 : 16'h1234;
      @(negedge clk);
      check("shift_bin_stable", 32'(bus.bin_d_out), 32'h0100);
    end
    bus.en = 1'b0;
    wait_rdy(40, ok);

    // Reset mid-conversion discards the partial result.
    bus.bcd_d_in = 16'h0999;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midconv_reset_rdy", 32'(bus.rdy), 32'd1);
    check("midconv_reset_bin", 32'(bus.bin_d_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(bus.rdy), 32'd1);
    convert(16'h0999, 14'h03E7);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
